prach_hb_sched: RTL and testbench

- Polyphase input scheduler for a TDM half-band decimator stage in the PRACH long-format chain.
- Accepts one interleaved sample stream, with channels round-robin 0..NUM_CHN-1 per sample period.
- Stores each channel's even-phase sample and, on that channel's odd-phase sample, issues the pair (dp1 = even/earlier, dp2 = odd/later) tagged with channel and sync.
- Supervises the channel sequence, drops input while out of lock, and flags sequence errors.

---
 rtl/prach_pkg.sv | 19 +
 rtl/prach_sdp_ram.sv | 36 +++
 rtl/prach_hb_sched.sv | 160 ++++++++++++++++
 tb/tb_prach_hb_sched.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prach_pkg.sv
// prach_pkg
// Shared definitions for the PRACH half-band input scheduler slice.
//   NumChannelUsed : TDM channels carried per sample period
//   DATA_W         : sample width
//   CHN_W          : channel index width
//   sched_state_t  : channel-sequence supervisor state
package prach_pkg;

    localparam int NumChannelUsed = 48;
    localparam int DATA_W         = 16;
    localparam int CHN_W          = 8;

    // HUNT waits for a sync on channel 0; RUN follows the round-robin sequence
    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

endpackage

// File: rtl/prach_sdp_ram.sv
// prach_sdp_ram
// Simple dual-port RAM holding one even-phase sample per channel.
// Registered read with one cycle of latency; contents are never reset.
// Ports:
//   clk     : clock
//   wr_en   : write enable
//   wr_addr : write address (channel index)
//   wr_data : write data
//   rd_addr : read address (channel index)
//   rd_data : registered read data, valid the cycle after rd_addr
module prach_sdp_ram
    import prach_pkg::*;
#(
    parameter int DEPTH  = NumChannelUsed,
    parameter int WIDTH  = DATA_W,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array and read register; no reset so this maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/prach_hb_sched.sv
// prach_hb_sched
// Polyphase input scheduler for a TDM half-band decimator stage.
// Channels arrive round-robin 0..NUM_CHN-1 per sample period. The even-phase
// sample of each channel is parked in a RAM; on the matching odd-phase sample
// the stored (earlier) and current (later) samples are issued as a pair.
// The channel sequence is supervised: input is dropped while out of lock and
// sequence errors raise a sticky flag.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   din_dq/dv/chn     : input sample, valid, channel index
//   sync_in           : frame start (channel 0, even phase), qualified by din_dv
//   dout_dp1/dp2      : even (earlier) / odd (later) sample of the pair
//   dout_dv/chn       : pair valid pulse / pair channel
//   sync_out          : first pair after a sync-qualified restart
//   err_seq, err_clr  : sticky sequence error and its clear
module prach_hb_sched
    import prach_pkg::*;
#(
    parameter int NUM_CHN = NumChannelUsed,
    parameter int CHN_W   = prach_pkg::CHN_W,
    parameter int DATA_W  = prach_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din_dq,
    input  logic              din_dv,
    input  logic [CHN_W-1:0]  din_chn,
    input  logic              sync_in,
    output logic [DATA_W-1:0] dout_dp1,
    output logic [DATA_W-1:0] dout_dp2,
    output logic              dout_dv,
    output logic [CHN_W-1:0]  dout_chn,
    output logic              sync_out,
    output logic              err_seq,
    input  logic              err_clr
);

    localparam int               ADDR_W   = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
    localparam logic [CHN_W-1:0] LAST_CHN = CHN_W'(NUM_CHN - 1);

    sched_state_t      state;
    logic [CHN_W-1:0]  exp_chn;
    logic              phase;
    logic              pending_sync;

    logic              restart;
    logic              in_seq;
    logic              mismatch;
    logic              hunt_err;
    logic              ram_we;
    logic              emit;
    logic              first_pair;

    logic              s1_vld;
    logic              s1_sync;
    logic [CHN_W-1:0]  s1_chn;
    logic [DATA_W-1:0] s1_dq;
    logic [DATA_W-1:0] ram_rdata;

    // A qualified sync on channel 0 restarts the sequence from any state and
    // makes the current sample the even half. Any other sync, or a channel
    // out of order while running, loses lock.
    assign restart    = din_dv && sync_in && (din_chn == '0);
    assign in_seq     = din_dv && (state == RUN) && !sync_in && (din_chn == exp_chn);
    assign mismatch   = din_dv && (state == RUN) && !restart && !in_seq;
    assign hunt_err   = din_dv && (state == HUNT) && sync_in && (din_chn != '0);
    assign ram_we     = restart || (in_seq && !phase);
    assign emit       = in_seq && phase;
    assign first_pair = emit && pending_sync && (din_chn == '0);

    prach_sdp_ram #(
        .DEPTH  (NUM_CHN),
        .WIDTH  (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (din_chn[ADDR_W-1:0]),
        .wr_data (din_dq),
        .rd_addr (din_chn[ADDR_W-1:0]),
        .rd_data (ram_rdata)
    );

    // Sequence supervisor: tracks expected channel and phase, toggling the
    // phase each time the channel index wraps. Only accepted samples advance it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= HUNT;
            exp_chn      <= '0;
            phase        <= 1'b0;
            pending_sync <= 1'b0;
        end else if (restart) begin
            state        <= RUN;
            exp_chn      <= CHN_W'(1);
            phase        <= 1'b0;
            pending_sync <= 1'b1;
        end else if (mismatch) begin
            state        <= HUNT;
            exp_chn      <= '0;
            phase        <= 1'b0;
            pending_sync <= 1'b0;
        end else if (in_seq) begin
            if (exp_chn == LAST_CHN) begin
                exp_chn <= '0;
                phase   <= ~phase;
            end else begin
                exp_chn <= exp_chn + CHN_W'(1);
            end
            if (first_pair) begin
                pending_sync <= 1'b0;
            end
        end
    end

    // Sticky sequence error; a new error in the same cycle outranks a clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_seq <= 1'b0;
        end else if (mismatch || hunt_err) begin
            err_seq <= 1'b1;
        end else if (err_clr) begin
            err_seq <= 1'b0;
        end
    end

    // Delay the odd sample and its tag by one cycle to line up with the RAM read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_sync <= 1'b0;
            s1_chn  <= '0;
            s1_dq   <= '0;
        end else begin
            s1_vld  <= emit;
            s1_sync <= first_pair;
            s1_chn  <= din_chn;
            s1_dq   <= din_dq;
        end
    end

    // Output register: dv and sync pulse for one cycle, pair data holds
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_dv  <= 1'b0;
            sync_out <= 1'b0;
            dout_dp1 <= '0;
            dout_dp2 <= '0;
            dout_chn <= '0;
        end else begin
            dout_dv  <= s1_vld;
            sync_out <= s1_sync;
            if (s1_vld) begin
                dout_dp1 <= ram_rdata;
                dout_dp2 <= s1_dq;
                dout_chn <= s1_chn;
            end
        end
    end

endmodule

// File: tb/tb_prach_hb_sched.sv
// tb_prach_hb_sched
// Directed bench for prach_hb_sched with 48 channels. Full rounds use the
// pattern din_dq = 2*chn + 1000*phase, so every pair is known in closed form;
// short corner-case sequences come from a table of expected outputs.
module tb_prach_hb_sched;

    localparam int NCH = 48;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din_dq;
    logic        din_dv;
    logic [7:0]  din_chn;
    logic        sync_in;
    logic [15:0] dout_dp1;
    logic [15:0] dout_dp2;
    logic        dout_dv;
    logic [7:0]  dout_chn;
    logic        sync_out;
    logic        err_seq;
    logic        err_clr;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int sync_viol = 0;

    typedef struct {
        logic [15:0] dp1;
        logic [15:0] dp2;
        logic [7:0]  chn;
        logic        sy;
        int          at;
    } cap_t;

    typedef struct {
        string       name;
        logic        rst;
        logic        dv;
        logic        sync;
        logic        clr;
        logic [7:0]  chn;
        logic [15:0] dq;
        logic        e_dv;
        logic        e_sync;
        logic        e_err;
        logic        e_data;
        logic [7:0]  e_chn;
        logic [15:0] e_dp1;
        logic [15:0] e_dp2;
    } vec_t;

    cap_t caps[$];
    int   odd_at[$];
    vec_t vecs[18];

    always #5 clk = ~clk;

    prach_hb_sched #(
        .NUM_CHN (NCH),
        .CHN_W   (8),
        .DATA_W  (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din_dq   (din_dq),
        .din_dv   (din_dv),
        .din_chn  (din_chn),
        .sync_in  (sync_in),
        .dout_dp1 (dout_dp1),
        .dout_dp2 (dout_dp2),
        .dout_dv  (dout_dv),
        .dout_chn (dout_chn),
        .sync_out (sync_out),
        .err_seq  (err_seq),
        .err_clr  (err_clr)
    );

    // Edge counter used to time-stamp accepted samples and emitted pairs
    always @(posedge clk) cyc <= cyc + 1;

    // Pair monitor, sampling on the falling edge away from register updates
    always @(negedge clk) begin
        if (dout_dv === 1'b1) caps.push_back('{dout_dp1, dout_dp2, dout_chn, sync_out, cyc});
        if (sync_out === 1'b1 && dout_dv !== 1'b1) sync_viol++;
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs; returns 1 time unit after the accepting edge
    task automatic applyStimulus(input logic dv, input logic [7:0] chn, input logic [15:0] dq,
                                 input logic sy, input logic clr);
        din_dv  = dv;
        din_chn = chn;
        din_dq  = dq;
        sync_in = sy;
        err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 8'd0, 16'd0, 1'b0, 1'b0);
    endtask

    // Invalid cycle carrying junk, including unqualified syncs on nonzero channels
    task automatic gap_cycle();
        applyStimulus(1'b0, 8'($urandom_range(1, 255)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    // Channels lo..hi of one phase; odd-phase accept times are logged in order
    task automatic drive_round(input int ph, input int lo, input int hi, input bit sy, input bit gaps);
        for (int c = lo; c <= hi; c++) begin
            if (gaps) repeat ($urandom_range(0, 2)) gap_cycle();
            applyStimulus(1'b1, 8'(c), 16'(c * 2 + ph * 1000), 1'(sy && c == lo), 1'b0);
            if (ph == 1) odd_at.push_back(cyc);
        end
    endtask

    // Pair k must be channel k mod 48 with dp1=2c, dp2=2c+1000, sync on the
    // first pair only, arriving one edge after the edge that accepted its odd sample
    task automatic check_pairs(input string name, input int base, input int obase, input int n);
        checkOutput($sformatf("%s pair count", name), 32'(caps.size() - base), 32'(n));
        for (int k = 0; k < n; k++) begin
            cap_t p;
            int   c;
            if (base + k >= caps.size()) break;
            p = caps[base + k];
            c = k % NCH;
            checkOutput($sformatf("%s pair%0d chn", name, k), 32'(p.chn), 32'(c));
            checkOutput($sformatf("%s pair%0d dp1", name, k), 32'(p.dp1), 32'(2 * c));
            checkOutput($sformatf("%s pair%0d dp2", name, k), 32'(p.dp2), 32'(2 * c + 1000));
            checkOutput($sformatf("%s pair%0d sync", name, k), 32'(p.sy), 32'(k == 0));
            checkOutput($sformatf("%s pair%0d latency", name, k), 32'(p.at), 32'(odd_at[obase + k] + 1));
        end
    endtask

    function automatic vec_t mk(input string n, input int rst, input int dv, input int sy, input int clr,
                                input int chn, input int dq, input int edv, input int esy, input int eerr,
                                input int edat, input int echn, input int edp1, input int edp2);
        vec_t v;
        v.name   = n;
        v.rst    = 1'(rst);
        v.dv     = 1'(dv);
        v.sync   = 1'(sy);
        v.clr    = 1'(clr);
        v.chn    = 8'(chn);
        v.dq     = 16'(dq);
        v.e_dv   = 1'(edv);
        v.e_sync = 1'(esy);
        v.e_err  = 1'(eerr);
        v.e_data = 1'(edat);
        v.e_chn  = 8'(echn);
        v.e_dp1  = 16'(edp1);
        v.e_dp2  = 16'(edp2);
        return v;
    endfunction

    // Each row is one input cycle; expectations hold just after its accepting edge
    task automatic apply_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            rst_n = !vecs[i].rst;
            applyStimulus(vecs[i].dv, vecs[i].chn, vecs[i].dq, vecs[i].sync, vecs[i].clr);
            checkOutput($sformatf("%s dv", vecs[i].name), 32'(dout_dv), 32'(vecs[i].e_dv));
            checkOutput($sformatf("%s sync_out", vecs[i].name), 32'(sync_out), 32'(vecs[i].e_sync));
            checkOutput($sformatf("%s err_seq", vecs[i].name), 32'(err_seq), 32'(vecs[i].e_err));
            if (vecs[i].e_data) begin
                checkOutput($sformatf("%s chn", vecs[i].name), 32'(dout_chn), 32'(vecs[i].e_chn));
                checkOutput($sformatf("%s dp1", vecs[i].name), 32'(dout_dp1), 32'(vecs[i].e_dp1));
                checkOutput($sformatf("%s dp2", vecs[i].name), 32'(dout_dp2), 32'(vecs[i].e_dp2));
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        int obase;

        //               name              rst dv sy clr chn dq       edv esy err dat echn dp1      dp2
        // Lock acquisition and error flag handling while hunting
        vecs[0]  = mk("A set beats clr",    0, 1, 1, 1,  3, 0,        0, 0, 1, 0, 0, 0,       0);
        vecs[1]  = mk("A clr",              0, 0, 0, 1,  0, 0,        0, 0, 0, 0, 0, 0,       0);
        vecs[2]  = mk("A unqualified sync", 0, 0, 1, 0,  2, 0,        0, 0, 0, 0, 0, 0,       0);
        vecs[3]  = mk("A hunt discard",     0, 1, 0, 0,  0, 5,        0, 0, 0, 0, 0, 0,       0);
        vecs[4]  = mk("A hunt lock",        0, 1, 1, 0,  0, 0,        0, 0, 0, 0, 0, 0,       0);
        // Re-sync arriving where the odd sample of channel 0 was due
        vecs[5]  = mk("B resync ph1",       0, 1, 1, 0,  0, 'h7777,   0, 0, 0, 0, 0, 0,       0);
        vecs[6]  = mk("B chn1 even",        0, 1, 0, 0,  1, 'h1111,   0, 0, 0, 0, 0, 0,       0);
        vecs[7]  = mk("B chn2 even",        0, 1, 0, 0,  2, 'h2222,   0, 0, 0, 0, 0, 0,       0);
        vecs[8]  = mk("C chn0 odd",         0, 1, 0, 0,  0, 'h8888,   0, 0, 0, 0, 0, 0,       0);
        vecs[9]  = mk("C pair chn0",        0, 1, 0, 0,  1, 'h9999,   1, 1, 0, 1, 0, 'h7777,  'h8888);
        vecs[10] = mk("C pair chn1",        0, 1, 0, 0,  2, 'hAAAA,   1, 0, 0, 1, 1, 'h1111,  'h9999);
        vecs[11] = mk("C pair chn2",        0, 0, 0, 0,  0, 0,        1, 0, 0, 1, 2, 'h2222,  'hAAAA);
        vecs[12] = mk("C pulse ends",       0, 0, 0, 0,  0, 0,        0, 0, 0, 0, 0, 0,       0);
        // Reset one clock after an odd sample
        vecs[13] = mk("D odd chn0",         0, 1, 0, 0,  0, 1000,     0, 0, 0, 0, 0, 0,       0);
        vecs[14] = mk("D reset",            1, 0, 0, 0,  0, 0,        0, 0, 0, 1, 0, 0,       0);
        vecs[15] = mk("D after reset",      0, 1, 0, 0,  1, 1002,     0, 0, 0, 1, 0, 0,       0);
        vecs[16] = mk("D still hunting",    0, 1, 0, 0,  2, 1004,     0, 0, 0, 1, 0, 0,       0);
        vecs[17] = mk("D quiet",            0, 0, 0, 0,  0, 0,        0, 0, 0, 1, 0, 0,       0);

        rst_n   = 1'b0;
        din_dv  = 1'b0;
        din_chn = 8'd0;
        din_dq  = 16'd0;
        sync_in = 1'b0;
        err_clr = 1'b0;

        $display("[TB] reset values");
        do_reset();
        checkOutput("reset dv", 32'(dout_dv), 32'd0);
        checkOutput("reset sync_out", 32'(sync_out), 32'd0);
        checkOutput("reset err_seq", 32'(err_seq), 32'd0);
        checkOutput("reset dp1", 32'(dout_dp1), 32'd0);
        checkOutput("reset dp2", 32'(dout_dp2), 32'd0);
        checkOutput("reset chn", 32'(dout_chn), 32'd0);

        $display("[TB] two rounds with sync");
        base  = caps.size();
        obase = odd_at.size();
        drive_round(0, 0, NCH - 1, 1'b1, 1'b0);
        drive_round(1, 0, NCH - 1, 1'b0, 1'b0);
        idle(4);
        check_pairs("T1", base, obase, NCH);
        checkOutput("T1 err_seq", 32'(err_seq), 32'd0);

        $display("[TB] two rounds without sync");
        do_reset();
        base = caps.size();
        drive_round(0, 0, NCH - 1, 1'b0, 1'b0);
        drive_round(1, 0, NCH - 1, 1'b0, 1'b0);
        idle(4);
        checkOutput("T2 no pairs", 32'(caps.size() - base), 32'd0);
        checkOutput("T2 err_seq", 32'(err_seq), 32'd0);

        $display("[TB] channel 7 in place of channel 5");
        do_reset();
        base  = caps.size();
        obase = odd_at.size();
        drive_round(0, 0, NCH - 1, 1'b1, 1'b0);
        drive_round(1, 0, 4, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd7, 16'(7 * 2 + 1000), 1'b0, 1'b0);
        checkOutput("T3 err after mismatch", 32'(err_seq), 32'd1);
        drive_round(1, 6, NCH - 1, 1'b0, 1'b0);
        drive_round(0, 0, NCH - 1, 1'b0, 1'b0);
        idle(4);
        check_pairs("T3 before error", base, obase, 5);
        base  = caps.size();
        obase = odd_at.size();
        drive_round(0, 0, NCH - 1, 1'b1, 1'b0);
        drive_round(1, 0, NCH - 1, 1'b0, 1'b0);
        idle(4);
        check_pairs("T3 resync", base, obase, NCH);
        checkOutput("T3 err sticky", 32'(err_seq), 32'd1);
        applyStimulus(1'b0, 8'd0, 16'd0, 1'b0, 1'b1);
        checkOutput("T3 err_clr", 32'(err_seq), 32'd0);

        $display("[TB] ten rounds with random gaps");
        do_reset();
        base  = caps.size();
        obase = odd_at.size();
        for (int r = 0; r < 5; r++) begin
            drive_round(0, 0, NCH - 1, 1'(r == 0), 1'b1);
            drive_round(1, 0, NCH - 1, 1'b0, 1'b1);
        end
        idle(4);
        check_pairs("T4", base, obase, 5 * NCH);

        $display("[TB] hunt and error flag table");
        do_reset();
        apply_vectors(0, 4);

        $display("[TB] resync at phase 1 table");
        do_reset();
        drive_round(0, 0, NCH - 1, 1'b1, 1'b0);
        apply_vectors(5, 7);
        drive_round(0, 3, NCH - 1, 1'b0, 1'b0);
        apply_vectors(8, 12);

        $display("[TB] reset after odd sample table");
        do_reset();
        drive_round(0, 0, NCH - 1, 1'b1, 1'b0);
        apply_vectors(13, 17);

        checkOutput("sync_out without dv", 32'(sync_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
